// File: rtl/addsub_nibble_seq.sv
// Multi-cycle N-bit add/subtract controller that feeds a 4-bit ripple add/sub slice one nibble per cycle.
// Results and flags are committed together at the end, with a start/busy/done handshake.

module addsub_slice4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       ci_i,
   output logic [3:0] s_o,
   output logic       c3_o,
   output logic       co_o
);
   logic [4:0] c;

   assign c[0] = ci_i;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fa
         assign s_o[gi]  = a_i[gi] ^ b_i[gi] ^ c[gi];
         assign c[gi+1]  = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
      end
   endgenerate

   assign c3_o = c[3];
   assign co_o = c[4];
endmodule

module addsub_nibble_seq #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         M,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] S,
   output logic         Co,
   output logic         V,
   output logic         Z,
   output logic         N,
   output logic         busy,
   output logic         done
);
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic              m_q, m_d;
   logic [W-1:0]      s_work_q, s_work_d;
   logic [W-1:0]      s_q, s_d;
   logic              co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d;

   logic [3:0]        a_nibs [NIBBLES];
   logic [3:0]        b_nibs [NIBBLES];
   logic [3:0]        slice_a, slice_b, slice_s;
   logic              slice_c3, slice_co;
   logic              last_nib;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign a_nibs[gi] = a_q[4*gi +: 4];
         assign b_nibs[gi] = b_q[4*gi +: 4];
      end
   endgenerate

   // Subtract is A + ~B + 1: invert B here, the +1 is the initial carry (= M).
   assign slice_a  = a_nibs[idx_q];
   assign slice_b  = b_nibs[idx_q] ^ {4{m_q}};
   assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

   addsub_slice4 u_slice (
      .a_i  (slice_a),
      .b_i  (slice_b),
      .ci_i (carry_q),
      .s_o  (slice_s),
      .c3_o (slice_c3),
      .co_o (slice_co)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      s_work_d = s_work_q;
      s_d      = s_q;
      co_d     = co_q;
      v_d      = v_q;
      z_d      = z_q;
      n_d      = n_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               m_d     = M;
               carry_d = M;
               idx_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDXW'(i)) s_work_d[4*i +: 4] = slice_s;
            end
            carry_d = slice_co;
            if (last_nib) begin
               // slice_c3 here is the carry into bit W-1.
               s_d     = s_work_d;
               co_d    = slice_co;
               v_d     = slice_c3 ^ slice_co;
               z_d     = (s_work_d == '0);
               n_d     = s_work_d[W-1];
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= 1'b0;
         s_work_q <= '0;
         s_q      <= '0;
         co_q     <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         s_work_q <= s_work_d;
         s_q      <= s_d;
         co_q     <= co_d;
         v_q      <= v_d;
         z_q      <= z_d;
         n_q      <= n_d;
      end
   end

   assign S    = s_q;
   assign Co   = co_q;
   assign V    = v_q;
   assign Z    = z_q;
   assign N    = n_q;
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed bench for addsub_nibble_seq: vector table plus hand-written handshake/reset sequences.

module tb_addsub_nibble_seq;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         M = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic [W-1:0] S;
   logic         Co, V, Z, N, busy, done;

   int checks = 0;
   int errors = 0;

   addsub_nibble_seq #(.NIBBLES(NIB)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .M     (M),
      .A     (A),
      .B     (B),
      .S     (S),
      .Co    (Co),
      .V     (V),
      .Z     (Z),
      .N     (N),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         m;
      logic [W-1:0] s;
      logic         co;
      logic         v;
      logic         z;
      logic         n;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_flags(input string name, input logic [W-1:0] s, input logic co,
                            input logic v, input logic z, input logic n);
      chk({name, ".S"}, S, s);
      chk({name, ".flags"}, {12'h0, Co, V, Z, N}, {12'h0, co, v, z, n});
   endtask

   // Start one operation at the next edge and check handshake timing and result.
   task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] s, input logic co, input logic v, input logic z,
                         input logic n);
      logic [W-1:0] s_prev;
      s_prev = S;
      @(negedge clk);
      A = a; B = b; M = m; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      A = ~a; B = ~b; M = ~m;
      for (int i = 0; i < NIB; i++) begin
         chk($sformatf("op%0d.busy_done_c%0d", id, i), {14'h0, busy, done}, 16'h0002);
         chk($sformatf("op%0d.S_hold_c%0d", id, i), S, s_prev);
         @(posedge clk);
         #1;
      end
      chk($sformatf("op%0d.busy_done_end", id), {14'h0, busy, done}, 16'h0001);
      chk_flags($sformatf("op%0d", id), s, co, v, z, n);
      $display("op%0d: A=%h B=%h M=%0d -> S=%h Co=%0d V=%0d Z=%0d N=%0d",
               id, a, b, m, S, Co, V, Z, N);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h0FCE, 1'b0, 16'h2202, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset.S", S, 16'h0000);
      chk("reset.flags_bd", {10'h0, Co, V, Z, N, busy, done}, 16'h0000);
      $display("reset: S=%h busy=%0d done=%0d", S, busy, done);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_op(i, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].s, vecs[i].co, vecs[i].v,
                vecs[i].z, vecs[i].n);

      // Start ignored during RUN, M latched, back-to-back accept from DONE.
      @(negedge clk);
      A = 16'h0001; B = 16'h0001; M = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= NIB; i++) begin
         @(negedge clk);
         A = 16'h0003; B = 16'h0001; M = 1'b1; start = 1'b1;
         @(posedge clk);
         #1;
         if (i < NIB) begin
            chk($sformatf("b2b.busy_c%0d", i), {14'h0, busy, done}, 16'h0002);
            chk($sformatf("b2b.S_hold_c%0d", i), S, 16'h0002);
         end
      end
      chk("b2b.first_done", {14'h0, busy, done}, 16'h0001);
      chk_flags("b2b.first", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("b2b first: S=%h Co=%0d", S, Co);
      @(posedge clk);
      #1;
      chk("b2b.accept_in_done", {14'h0, busy, done}, 16'h0002);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NIB - 1; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("b2b.second_busy_c%0d", i), {14'h0, busy, done}, 16'h0002);
         chk($sformatf("b2b.second_S_hold_c%0d", i), S, 16'h0002);
      end
      @(posedge clk);
      #1;
      chk("b2b.second_done", {14'h0, busy, done}, 16'h0001);
      chk_flags("b2b.second", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
      $display("b2b second: S=%h Co=%0d", S, Co);

      // Reset mid-operation.
      @(negedge clk);
      A = 16'h00FF; B = 16'h0001; M = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst.S", S, 16'h0000);
      chk("midrst.flags_bd", {10'h0, Co, V, Z, N, busy, done}, 16'h0000);
      $display("mid-op reset: S=%h busy=%0d done=%0d", S, busy, done);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NIB + 2; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("midrst.idle_c%0d", i), {14'h0, busy, done}, 16'h0000);
      end
      run_op(7, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
